// File: rtl/ball_overlay.sv
// Composites a bouncing square ball onto the background VGA stream, one pixel late.
// Ball position advances once per frame (vsync rising edge) under an IDLE/SERVE/RUN FSM.
module ball_overlay #(
    parameter int          FIELD_X_MIN  = 264,
    parameter int          FIELD_X_MAX  = 463,
    parameter int          FIELD_Y_MIN  = 75,
    parameter int          FIELD_Y_MAX  = 474,
    parameter int          BALL_SIZE    = 8,
    parameter int          SPEED        = 2,
    parameter int          START_X      = 360,
    parameter int          START_Y      = 271,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [23:0] BALL_RGB     = 24'hFFFFFF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_pix_en,
    input  logic [9:0] i_x,
    input  logic [9:0] i_y,
    input  logic       i_hsync,
    input  logic       i_vsync,
    input  logic [7:0] i_red,
    input  logic [7:0] i_green,
    input  logic [7:0] i_blue,
    input  logic       i_start,
    input  logic       i_stop,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [7:0] o_red,
    output logic [7:0] o_green,
    output logic [7:0] o_blue,
    output logic [1:0] o_state,
    output logic [7:0] o_bounces
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE = 2'd1, RUN = 2'd2} state_t;

    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam logic [10:0] BS   = 11'(BALL_SIZE);
    localparam logic [10:0] SPD  = 11'(SPEED);
    localparam logic [10:0] XMIN = 11'(FIELD_X_MIN);
    localparam logic [10:0] XMAX = 11'(FIELD_X_MAX);
    localparam logic [10:0] YMIN = 11'(FIELD_Y_MIN);
    localparam logic [10:0] YMAX = 11'(FIELD_Y_MAX);

    // Returns {bounced, new_dir, new_pos}; 11-bit compares avoid wrap/underflow.
    function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir,
                                              input logic [10:0] lo, input logic [10:0] hi);
        logic [10:0] p;
        p = {1'b0, pos};
        if (dir) begin
            if (p + SPD + BS - 11'd1 > hi) step_axis = {1'b1, 1'b0, 10'(hi - BS + 11'd1)};
            else                           step_axis = {1'b0, 1'b1, 10'(p + SPD)};
        end else begin
            if (p < lo + SPD) step_axis = {1'b1, 1'b1, 10'(lo)};
            else              step_axis = {1'b0, 1'b0, 10'(p - SPD)};
        end
    endfunction

    state_t          state_q, state_d;
    logic [9:0]      bx_q, bx_d, by_q, by_d;
    logic            dx_q, dx_d, dy_q, dy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      bnc_q, bnc_d;
    logic            vsd_q;
    logic            hs_q, vs_q;
    logic [23:0]     rgb_q;

    logic            tick, hit;
    logic            bx_b, dx_n, by_b, dy_n;
    logic [9:0]      bx_n, by_n;
    logic [CW-1:0]   cnt_inc;

    assign tick    = i_vsync & ~vsd_q;
    assign cnt_inc = cnt_q + CW'(1);
    assign {bx_b, dx_n, bx_n} = step_axis(bx_q, dx_q, XMIN, XMAX);
    assign {by_b, dy_n, by_n} = step_axis(by_q, dy_q, YMIN, YMAX);

    assign hit = ({1'b0, i_x} >= {1'b0, bx_q}) && ({1'b0, i_x} < {1'b0, bx_q} + BS) &&
                 ({1'b0, i_y} >= {1'b0, by_q}) && ({1'b0, i_y} < {1'b0, by_q} + BS);

    always_comb begin
        state_d = state_q;
        bx_d    = bx_q;
        by_d    = by_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        bnc_d   = bnc_q;
        case (state_q)
            IDLE: begin
                if (i_start && !i_stop) begin
                    state_d = SERVE;
                    cnt_d   = '0;
                    bnc_d   = '0;
                end
            end
            SERVE, RUN: begin
                if (i_stop) begin
                    // Back to IDLE re-arms the serve position; bounce count is kept.
                    state_d = IDLE;
                    bx_d    = 10'(START_X);
                    by_d    = 10'(START_Y);
                    dx_d    = 1'b1;
                    dy_d    = 1'b1;
                end else if (tick && state_q == SERVE) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CW'(SERVE_FRAMES)) state_d = RUN;
                end else if (tick) begin
                    bx_d = bx_n;
                    dx_d = dx_n;
                    by_d = by_n;
                    dy_d = dy_n;
                    if ((bx_b || by_b) && bnc_q != 8'hFF) bnc_d = bnc_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bx_q    <= 10'(START_X);
            by_q    <= 10'(START_Y);
            dx_q    <= 1'b1;
            dy_q    <= 1'b1;
            cnt_q   <= '0;
            bnc_q   <= '0;
            vsd_q   <= 1'b0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            rgb_q   <= '0;
        end else if (i_pix_en) begin
            state_q <= state_d;
            bx_q    <= bx_d;
            by_q    <= by_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
            bnc_q   <= bnc_d;
            vsd_q   <= i_vsync;
            hs_q    <= i_hsync;
            vs_q    <= i_vsync;
            rgb_q   <= hit ? BALL_RGB : {i_red, i_green, i_blue};
        end
    end

    assign o_hsync   = hs_q;
    assign o_vsync   = vs_q;
    assign {o_red, o_green, o_blue} = rgb_q;
    assign o_state   = state_q;
    assign o_bounces = bnc_q;
endmodule

// File: tb/tb_ball_overlay.sv
// Scoreboard bench for ball_overlay: three instances (default, corner start, tiny field)
// share one stimulus stream; a frame-level model predicts every output.
module tb_ball_overlay;
    logic       clk = 1'b0, rst_n = 1'b0, pix_en = 1'b0;
    logic [9:0] x = '0, y = '0;
    logic       hs = 1'b0, vs = 1'b0, start = 1'b0, stop = 1'b0;
    logic [7:0] r = '0, g = '0, b = '0;

    logic       hs_o [3];
    logic       vs_o [3];
    logic [7:0] r_o  [3];
    logic [7:0] g_o  [3];
    logic [7:0] b_o  [3];
    logic [1:0] st_o [3];
    logic [7:0] bn_o [3];

    int n_chk = 0, n_fail = 0;
    logic [23:0] bg = 24'h03344F;
    logic [2:0][25:0] sb[$];
    logic [2:0][25:0] last_e;

    // Model parameters and state per instance
    int mxmin[3] = '{264, 264, 264};
    int mxmax[3] = '{463, 463, 275};
    int mymin[3] = '{75, 75, 75};
    int mymax[3] = '{474, 474, 86};
    int msx[3]   = '{360, 454, 266};
    int msy[3]   = '{271, 465, 75};
    int  mbx[3], mby[3], mst[3], mcnt[3], mbnc[3];
    bit  mdx[3], mdy[3];
    bit  mvsd;

    always #10 clk = ~clk;

    ball_overlay u0 (.clk(clk), .rst_n(rst_n), .i_pix_en(pix_en), .i_x(x), .i_y(y),
        .i_hsync(hs), .i_vsync(vs), .i_red(r), .i_green(g), .i_blue(b), .i_start(start),
        .i_stop(stop), .o_hsync(hs_o[0]), .o_vsync(vs_o[0]), .o_red(r_o[0]), .o_green(g_o[0]),
        .o_blue(b_o[0]), .o_state(st_o[0]), .o_bounces(bn_o[0]));
    ball_overlay #(.START_X(454), .START_Y(465)) u1 (.clk(clk), .rst_n(rst_n),
        .i_pix_en(pix_en), .i_x(x), .i_y(y), .i_hsync(hs), .i_vsync(vs), .i_red(r),
        .i_green(g), .i_blue(b), .i_start(start), .i_stop(stop), .o_hsync(hs_o[1]),
        .o_vsync(vs_o[1]), .o_red(r_o[1]), .o_green(g_o[1]), .o_blue(b_o[1]),
        .o_state(st_o[1]), .o_bounces(bn_o[1]));
    ball_overlay #(.FIELD_X_MAX(275), .FIELD_Y_MAX(86), .START_X(266), .START_Y(75)) u2 (
        .clk(clk), .rst_n(rst_n), .i_pix_en(pix_en), .i_x(x), .i_y(y), .i_hsync(hs),
        .i_vsync(vs), .i_red(r), .i_green(g), .i_blue(b), .i_start(start), .i_stop(stop),
        .o_hsync(hs_o[2]), .o_vsync(vs_o[2]), .o_red(r_o[2]), .o_green(g_o[2]),
        .o_blue(b_o[2]), .o_state(st_o[2]), .o_bounces(bn_o[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] rgb(input int k);
        return {r_o[k], g_o[k], b_o[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mbx[k] = msx[k]; mby[k] = msy[k]; mdx[k] = 1'b1; mdy[k] = 1'b1;
            mst[k] = 0; mcnt[k] = 0; mbnc[k] = 0;
        end
        mvsd = 1'b0;
    endtask

    task automatic axis(inout int p, inout bit d, output bit bo, input int lo, input int hi);
        bo = 1'b0;
        if (d) begin
            if (p + 2 + 7 > hi) begin p = hi - 7; d = 1'b0; bo = 1'b1; end
            else p = p + 2;
        end else begin
            if (p < lo + 2) begin p = lo; d = 1'b1; bo = 1'b1; end
            else p = p - 2;
        end
    endtask

    task automatic model_step(input bit pst, input bit psp, input bit pvs);
        bit tk, bxo, byo;
        tk = pvs && !mvsd;
        mvsd = pvs;
        for (int k = 0; k < 3; k++) begin
            if (mst[k] != 0 && psp) begin
                mst[k] = 0; mbx[k] = msx[k]; mby[k] = msy[k]; mdx[k] = 1'b1; mdy[k] = 1'b1;
            end else if (mst[k] == 0 && pst && !psp) begin
                mst[k] = 1; mcnt[k] = 0; mbnc[k] = 0;
            end else if (mst[k] == 1 && tk) begin
                mcnt[k]++;
                if (mcnt[k] == 60) mst[k] = 2;
            end else if (mst[k] == 2 && tk) begin
                axis(mbx[k], mdx[k], bxo, mxmin[k], mxmax[k]);
                axis(mby[k], mdy[k], byo, mymin[k], mymax[k]);
                if ((bxo || byo) && mbnc[k] < 255) mbnc[k]++;
            end
        end
    endtask

    // One pixel strobe: one enabled clock followed by one idle clock.
    task automatic strobe(input int px, input int py, input bit phs, input bit pvs,
                          input logic [23:0] prgb, input bit pst, input bit psp);
        logic [2:0][25:0] e;
        bit hit;
        @(negedge clk);
        x = 10'(px); y = 10'(py); hs = phs; vs = pvs; {r, g, b} = prgb;
        start = pst; stop = psp; pix_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            hit = px >= mbx[k] && px < mbx[k] + 8 && py >= mby[k] && py < mby[k] + 8;
            e[k] = {phs, pvs, hit ? 24'hFFFFFF : prgb};
        end
        sb.push_back(e);
        model_step(pst, psp, pvs);
        @(posedge clk); #1;
        pix_en = 1'b0; start = 1'b0; stop = 1'b0;
        e = sb.pop_front();
        last_e = e;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("out%0d", k), 32'({hs_o[k], vs_o[k], rgb(k)}), 32'(e[k]));
            chk($sformatf("state%0d", k), 32'(st_o[k]), 32'(mst[k]));
            chk($sformatf("bounces%0d", k), 32'(bn_o[k]), 32'(mbnc[k]));
        end
        @(posedge clk); #1;
    endtask

    // One frame tick, then a probe pixel around the main ball.
    task automatic frame();
        strobe(int'($urandom_range(0, 799)), 0, 1'b1, 1'b1, bg, 1'b0, 1'b0);
        strobe(mbx[0] - 2 + int'($urandom_range(0, 11)), mby[0] - 2 + int'($urandom_range(0, 11)),
               1'b0, 1'b0, 24'($urandom), 1'b0, 1'b0);
    endtask

    task automatic probe(input string tag, input int k, input int px, input int py,
                         input logic [23:0] exp);
        strobe(px, py, 1'b1, 1'b0, bg, 1'b0, 1'b0);
        chk(tag, 32'(rgb(k)), 32'(exp));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bsave;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out", 32'({hs_o[k], vs_o[k], rgb(k)}), 32'd0);
            chk("rst_state", 32'(st_o[k]), 32'd0);
            chk("rst_bounces", 32'(bn_o[k]), 32'd0);
        end
        @(negedge clk) rst_n = 1'b1;

        // Mid-frame async reset
        repeat (3) strobe(int'($urandom_range(0, 799)), 100, 1'b1, 1'b1, 24'($urandom), 1'b0, 1'b0);
        strobe(360, 271, 1'b1, 1'b1, bg, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk("midrst_out", 32'({hs_o[k], vs_o[k], rgb(k)}), 32'd0);
        sb.delete();
        model_reset();
        @(negedge clk) rst_n = 1'b1;

        // Compositing at the serve position
        probe("hit_360_271", 0, 360, 271, 24'hFFFFFF);
        probe("miss_368_271", 0, 368, 271, bg);
        probe("hit_367_278", 0, 367, 278, 24'hFFFFFF);
        probe("miss_359_271", 0, 359, 271, bg);

        // Clock-enable hold
        probe("pre_hold", 0, 360, 271, 24'hFFFFFF);
        @(negedge clk);
        x = 10'd0; y = 10'd0; hs = 1'b0; vs = 1'b1; {r, g, b} = 24'h123456; start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_out", 32'({hs_o[0], vs_o[0], rgb(0)}), 32'(last_e[0]));
        chk("hold_state", 32'(st_o[0]), 32'd0);
        start = 1'b0; vs = 1'b0;

        // Serve timing
        strobe(0, 0, 1'b0, 1'b0, bg, 1'b1, 1'b0);
        chk("serve_enter", 32'(st_o[0]), 32'd1);
        for (int i = 1; i <= 60; i++) begin
            frame();
            if (i == 59) chk("serve_59", 32'(st_o[0]), 32'd1);
        end
        chk("run_at_60", 32'(st_o[0]), 32'd2);
        probe("still_start", 0, 360, 271, 24'hFFFFFF);
        probe("still_edge", 0, 368, 271, bg);

        // RUN ticks 1..3: main and corner instance
        frame();
        probe("run1_hit", 0, 362, 273, 24'hFFFFFF);
        probe("run1_miss", 0, 361, 272, bg);
        probe("corner1_hit", 1, 456, 467, 24'hFFFFFF);
        probe("corner1_miss", 1, 455, 466, bg);
        frame();
        chk("corner2_bounces", 32'(bn_o[1]), 32'd1);
        probe("corner2_hold", 1, 456, 467, 24'hFFFFFF);
        frame();
        probe("corner3_hit", 1, 454, 465, 24'hFFFFFF);
        probe("corner3_miss", 1, 462, 465, bg);

        // Right-wall bounce on the main instance
        for (int i = 4; i <= 48; i++) frame();
        probe("run48_hit", 0, 456, 367, 24'hFFFFFF);
        probe("run48_miss", 0, 455, 367, bg);
        chk("run48_bounces", 32'(bn_o[0]), 32'd0);
        frame();
        chk("run49_bounces", 32'(bn_o[0]), 32'd1);
        probe("run49_hit", 0, 456, 369, 24'hFFFFFF);
        frame();
        probe("run50_hit", 0, 454, 371, 24'hFFFFFF);
        probe("run50_miss", 0, 462, 371, bg);

        // Saturation on the tiny field
        for (int i = 51; i <= 600; i++) frame();
        chk("sat_bounces", 32'(bn_o[2]), 32'd255);

        // Stop beats start; bounce count held, then cleared on next serve
        bsave = mbnc[0];
        strobe(0, 0, 1'b0, 1'b0, bg, 1'b1, 1'b1);
        chk("stop_state", 32'(st_o[0]), 32'd0);
        chk("stop_bounces", 32'(bn_o[0]), 32'(bsave));
        probe("stop_pos", 0, 360, 271, 24'hFFFFFF);
        strobe(0, 0, 1'b0, 1'b0, bg, 1'b1, 1'b0);
        chk("restart_state", 32'(st_o[0]), 32'd1);
        chk("restart_bounces", 32'(bn_o[0]), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ball_overlay.md
Name: ball_overlay

Overview:
- Downstream of the VGA background generator.
- Takes the background's pixel counters, syncs and RGB, and draws a moving square ball inside the dark playfield column (x 264..463, y 75..474 in counter coordinates).
- Ball position updates once per frame under a small serve/run state machine and bounces off the playfield walls.
- Output is the background stream delayed by one pixel, with the ball composited on top; it feeds the VGA DAC pins.

Parameters:
- FIELD_X_MIN, 264, left playfield bound (counter_x units, inclusive)
- FIELD_X_MAX, 463, right playfield bound (inclusive)
- FIELD_Y_MIN, 75, top playfield bound (inclusive)
- FIELD_Y_MAX, 474, bottom playfield bound (inclusive)
- BALL_SIZE, 8, ball edge length in pixels
- SPEED, 2, pixels moved per frame per axis
- START_X, 360, serve position, top-left x
- START_Y, 271, serve position, top-left y
- SERVE_FRAMES, 60, frames spent in SERVE before RUN
- BALL_RGB, 24'hFFFFFF, ball colour {red, green, blue}

Ports:
- clk  in  1  system clock (50 MHz)
- rst_n  in  1  reset, asynchronous, active-low
- i_pix_en  in  1  one-cycle pixel strobe (25 MHz rate); all state advances only when high
- i_x  in  10  horizontal pixel counter
- i_y  in  10  vertical pixel counter
- i_hsync  in  1  horizontal sync from background stage
- i_vsync  in  1  vertical sync, active-high
- i_red, i_green, i_blue  in  8 each  background colour
- i_start  in  1  level; leaves IDLE
- i_stop  in  1  level; returns to IDLE
- o_hsync, o_vsync  out  1 each  syncs delayed one pixel
- o_red, o_green, o_blue  out  8 each  composited colour
- o_state  out  2  0 = IDLE, 1 = SERVE, 2 = RUN
- o_bounces  out  8  wall-bounce count, saturating

Behaviour:
- Reset (async, rst_n low):
  - All outputs are 0; state IDLE.
  - bx = START_X, by = START_Y; dx = +1, dy = +1.
  - Serve counter 0; vsync_d = 0.
- Clock enable: every register except the async reset path updates only on clk edges with i_pix_en = 1. With i_pix_en = 0, all state and outputs hold.
- Pipeline:
  - Latency is exactly one pixel strobe. o_hsync/o_vsync/o_rgb at strobe n reflect the inputs at strobe n-1.
  - ball_hit = (bx <= i_x < bx+BALL_SIZE) and (by <= i_y < by+BALL_SIZE), using the current bx/by.
  - Output RGB = BALL_RGB when ball_hit, else the input RGB.
- Frame tick: tick = i_vsync and not vsync_d, with vsync_d registered on the strobe. Exactly one tick per frame, so position never changes mid-frame.
- IDLE: ball is drawn at the start position. i_start = 1 → SERVE; serve counter and o_bounces are cleared.
- SERVE:
  - Ball is held at the start position.
  - Each tick increments the serve counter.
  - On the tick where the counter reaches SERVE_FRAMES → RUN; the ball does not move on that tick.
- RUN, on each tick, evaluated per axis (x shown; y is identical with by/dy/FIELD_Y_*):
  - dx = +1 and bx+SPEED+BALL_SIZE-1 > FIELD_X_MAX: bx = FIELD_X_MAX-BALL_SIZE+1; dx = -1; bounce.
  - dx = -1 and bx < FIELD_X_MIN+SPEED: bx = FIELD_X_MIN; dx = +1; bounce.
  - Otherwise bx = bx ± SPEED.
- Bounce counting: o_bounces increments by 1 per tick if either axis bounced, so a corner counts as 1. It saturates at 255.
- Priority and stop:
  - i_stop beats i_start. i_stop in SERVE or RUN → IDLE on that strobe.
  - Entering IDLE reloads the start position and dx = dy = +1; o_bounces is held.
  - i_start while in SERVE or RUN is ignored.
- Arithmetic: positions are unsigned 10-bit. Bound comparisons use 11-bit intermediates, so there is no wrap at 1023 and no underflow below FIELD_MIN.
- Parameter constraint: the field must lie inside the visible area, and FIELD_MAX - FIELD_MIN + 1 >= BALL_SIZE + SPEED.

Test Plan:
- Reset and compositing:
  - Drive rst_n low mid-frame → all outputs 0, o_state 0.
  - Release rst_n, background 0x03/0x34/0x4F. Pixel (360,271) → o_rgb FFFFFF one strobe later.
  - Pixel (368,271) → 03/34/4F.
  - With i_pix_en held low for 5 clocks → outputs unchanged.
- Serve timing: pulse i_start, then 60 vsync rising edges → o_state = 2 on the 60th tick, ball still at (360,271). Next tick → ball at (362,273).
- Right-wall bounce:
  - Tick 48 of RUN → bx = 456, o_bounces 0.
  - Tick 49 → bx = 456, dx = -1, o_bounces = 1.
  - Tick 50 → bx = 454.
- Corner: with START_X = 454 and START_Y = 465:
  - RUN tick 1 → (456,467).
  - Tick 2 → both axes flip, o_bounces = 1 (not 2).
  - Tick 3 → (454,465).
- Stop/priority:
  - i_start and i_stop both high in RUN → IDLE next strobe; position (360,271); o_bounces held.
  - Then i_start → o_bounces = 0, state SERVE.
- Saturation: with a 12x12 field, BALL_SIZE 8, SPEED 2, run 600 frames → o_bounces sticks at 255, no wrap to 0.
